booth_r4_multiplier: RTL and testbench

Parametrised radix-4 Booth sequential multiplier; successor to the 32-bit radix-2 Booth datapath. Handles WIDTH-bit operands in signed or unsigned mode, retires two multiplier bits per clock and presents a registered 2·WIDTH-bit product under an op_start/op_done/op_clear handshake. It sits as a standalone arithmetic slave beside the existing CLA adders and is driven by the same controller style.

---
 rtl/booth_r4_multiplier.sv | 99 +++++++++
 tb/tb_booth_r4_multiplier.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/booth_r4_multiplier.sv
// booth_r4_multiplier: radix-4 Booth sequential multiplier, optional MUL_ZERO_SKIP_EN zero-operand bypass
module booth_r4_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);
  localparam int E = WIDTH + 2;
  localparam int N = E / 2;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10} state_t;
  state_t state;
  logic [E:0] u, m, pp, sum, u_n;
  logic [E-1:0] v, x, v_n;
  logic x0, skip;
  logic [CW-1:0] cnt;
  logic [2:0] code;
`ifdef MUL_ZERO_SKIP_EN
  assign skip = multiplicand == '0 || multiplier == '0;
`else
  assign skip = 1'b0;
`endif
  // one Booth step: select partial product, add, arithmetic shift {U,V} right by 2
  always_comb begin
    code = {x[1:0], x0};
    pp = (code == 3'b001 || code == 3'b010) ? m :
         code == 3'b011 ? m << 1 :
         code == 3'b100 ? -(m << 1) :
         (code == 3'b101 || code == 3'b110) ? -m : '0;
    sum = u + pp;
    u_n = {sum[E], sum[E], sum[E:2]};
    v_n = {sum[1:0], v[E-1:2]};
  end
  // control FSM and datapath registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      u <= '0;
      v <= '0;
      x <= '0;
      x0 <= 1'b0;
      cnt <= '0;
      m <= '0;
      result <= '0;
      busy <= 1'b0;
      op_done <= 1'b0;
    end else if (op_clear) begin
      state <= IDLE;
      result <= '0;
      cnt <= '0;
      busy <= 1'b0;
      op_done <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (op_start && skip) begin
            state <= DONE;
            result <= '0;
            op_done <= 1'b1;
          end else if (op_start) begin
            state <= EXEC;
            busy <= 1'b1;
            m <= {{3{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
            x <= {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
            u <= '0;
            v <= '0;
            x0 <= 1'b0;
            cnt <= '0;
          end
        EXEC: begin
          u <= u_n;
          v <= v_n;
          x <= x >> 2;
          x0 <= x[1];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            op_done <= 1'b1;
            result <= {u_n[WIDTH-3:0], v_n};
          end
        end
        DONE: ;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          op_done <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_booth_r4_multiplier.sv
// tb_booth_r4_multiplier: randomized and directed checks of booth_r4_multiplier against an arithmetic model
module tb_booth_r4_multiplier;
  localparam int W = 32;
  localparam int LAT = W / 2 + 1;
  logic clk = 1'b0, reset = 1'b1, op_start = 1'b0, op_clear = 1'b0, is_signed = 1'b0;
  logic [W-1:0] multiplicand = '0, multiplier = '0;
  logic busy, op_done;
  logic [2*W-1:0] result;
  int tests = 0, fails = 0;

  booth_r4_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_clear(op_clear),
    .is_signed(is_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .op_done(op_done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[W-1]}}, a} : {32'b0, a};
    eb = s ? {{32{b[W-1]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
    return (a == '0 || b == '0) ? 0 : LAT;
`else
    return LAT;
`endif
  endfunction

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    multiplicand = a;
    multiplier = b;
    is_signed = s;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    is_signed = $urandom_range(0, 1);
  endtask

  task automatic clear();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    check("clr_done", {63'b0, op_done}, 64'd0);
    check("clr_result", result, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int lat;
    int el;
    el = exp_lat(a, b);
    start(a, b, s);
    check({tag, "_busy"}, {63'b0, busy}, {63'b0, el != 0});
    lat = 0;
    while (!op_done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_busy_done"}, {63'b0, busy}, 64'd0);
    check({tag, "_res"}, result, model(a, b, s));
    clear();
  endtask

  initial begin
    logic [63:0] held;
    #12;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, op_done}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("neg3x7", 32'hFFFFFFFD, 32'd7, 1'b1);
    check("neg3x7_const", model(32'hFFFFFFFD, 32'd7, 1'b1), 64'hFFFFFFFF_FFFFFFEB);
    run_op("ffff_u", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("ffff_s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run_op("min_s", 32'h80000000, 32'h80000000, 1'b1);
    run_op("zero_m", 32'd0, 32'h12345678, 1'b0);
    run_op("zero_q", 32'h9ABCDEF0, 32'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = (i % 10 == 9) ? '0 : W'($urandom);
      b = (i % 7 == 6) ? 32'h7FFFFFFF : W'($urandom);
      run_op($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)));
    end
    start(32'd1234, 32'd5678, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    clear();
    check("abort_busy", {63'b0, busy}, 64'd0);
    run_op("after_abort", 32'd100, 32'd200, 1'b0);
    check("abort_const", model(32'd100, 32'd200, 1'b0), 64'd20000);
    start(32'h00012345, 32'hFFFF0001, 1'b1);
    repeat (LAT) @(posedge clk);
    #1;
    check("hold_done0", {63'b0, op_done}, 64'd1);
    held = result;
    check("hold_res0", held, model(32'h00012345, 32'hFFFF0001, 1'b1));
    @(negedge clk);
    op_start = 1'b1;
    multiplicand = 32'd3;
    multiplier = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", {63'b0, op_done}, 64'd1);
    check("hold_busy", {63'b0, busy}, 64'd0);
    check("hold_res", result, held);
    op_start = 1'b0;
    clear();
    start(32'h7654321, 32'h1111, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    check("mid_busy_pre", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, op_done}, 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("arst_no_done", {63'b0, op_done}, 64'd0);
    run_op("post_rst", 32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
